sbox_serial_ctrl: RTL
=====================

Name: sbox_serial_ctrl

Overview:
Sequencing controller that applies the shared 5-bit sBoxLayer S-box to every 5-bit word of a wide state block, one word per clock. It accepts a full block over a valid/ready handshake and time-multiplexes a single sBoxLayer instance across all words. It returns the substituted block over a second valid/ready handshake. It sits in the cipher round datapath between the key-add stage and the permutation stage.

Parameters:
NUM_WORDS, 8, number of 5-bit words per block; legal range 2..32.
SBOX_W, 5, S-box word width; fixed at 5 to match sBoxLayer.
IDX_W, $clog2(NUM_WORDS), width of the word index counter; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data holds a block to process.
in_ready  output  1  controller can accept a block this cycle.
in_data  input  NUM_WORDS*SBOX_W  input block; word i = in_data[SBOX_W*i+4 : SBOX_W*i].
out_valid  output  1  out_data holds a completed block.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  NUM_WORDS*SBOX_W  substituted block; word i = S(input word i).
busy  output  1  high in RUN state.

Behaviour:
- FSM states: IDLE, RUN, DONE. All state and data registers reset asynchronously on rst=1.
- Reset values: state=IDLE, idx=0, out_valid=0, busy=0, out_data=0, input buffer=0.
- in_ready is combinational and equals (state==IDLE), so it reads 1 right after reset.
- IDLE: a transfer occurs when in_valid && in_ready at a rising edge.
  - On transfer: capture in_data into the input buffer, clear idx to 0, go to RUN.
  - in_data is ignored in every other state.
- RUN: the sBoxLayer input is buffer word[idx].
  - Each edge: result word[idx] <= Sx, idx <= idx+1.
  - When idx==NUM_WORDS-1, the edge writes the last word, sets state=DONE, and clears idx to 0.
  - RUN lasts exactly NUM_WORDS cycles. Words are processed LSB word first.
- DONE: out_valid=1 and out_data holds the full result, stable until the handshake.
  - When out_valid && out_ready at an edge, go to IDLE and clear out_valid.
  - No new block is accepted in the same cycle as the output handshake; in_ready rises the cycle after.
- Latency: the input handshake at edge E0 gives out_valid=1 after edge E0+NUM_WORDS.
- Throughput: one block per NUM_WORDS+2 cycles when out_ready is held at 1.
- Backpressure: DONE persists indefinitely while out_ready=0. out_data and out_valid do not change, and in_ready stays 0.
- out_ready is ignored outside DONE.
- Reset mid-operation (RUN or DONE): immediate return to IDLE, out_valid=0, and the partial result is discarded with no output.
- The sBoxLayer input is driven from the buffer in IDLE/DONE too (word 0); its value is don't-care there.
- idx never exceeds NUM_WORDS-1; there is no wrap-around into RUN without a new input handshake.

Decomposition:
- Shared package:
  - SBOX_W=5.
  - FSM state encoding typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Word-slice helper function word_of(block, i).
- One sub-module: the existing sBoxLayer (ports x[4:0], Sx[4:0]), instantiated once.
- The controller holds the FSM, idx counter, input buffer and result register.

Test Plan:
1. Reset, then in_data=0, in_valid=1 for one cycle.
   -> in_ready=1 before the handshake and 0 after; busy=1 for 8 cycles; out_valid=1 on cycle 9; each out_data word = S(5'd0).
2. Block with word i = i (i=0..7), out_ready=1.
   -> out_data word i = S(i); out_valid high exactly 1 cycle; in_ready returns to 1 the cycle after.
3. Four back-to-back blocks covering words 0..31 (block k, word i = 8k+i).
   -> every 32-entry S-box mapping matches the golden sBoxLayer table; handshakes are spaced 10 cycles apart.
4. Block completes with out_ready=0 for 5 cycles, then out_ready=1.
   -> out_valid stays 1 and out_data is bit-stable for all 5 cycles; in_ready stays 0; one transfer occurs.
5. rst pulsed high asynchronously mid-RUN (idx=3), then a new block is sent.
   -> out_valid=0 and in_ready=1 immediately; no output for the aborted block; the new block's output is correct.
6. in_valid held high during RUN/DONE with changing in_data.
   -> in_data changes are not captured; output reflects only the block accepted in IDLE.

Source files
------------

// File: rtl/sbox_serial_ctrl_pkg.sv
// Shared definitions for the serial S-box controller: word width, FSM encoding
// and a helper that slices one 5-bit word out of a block.
package sbox_serial_ctrl_pkg;

  localparam int SBOX_W      = 5;
  localparam int MAX_WORDS   = 32;
  localparam int MAX_BLOCK_W = MAX_WORDS * SBOX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Blocks narrower than MAX_BLOCK_W are zero-extended by the caller.
  function automatic logic [SBOX_W-1:0] word_of(
    input logic [MAX_BLOCK_W-1:0] block,
    input logic [4:0]             i
  );
    return block[SBOX_W*i +: SBOX_W];
  endfunction

endpackage

// File: rtl/sBoxLayer.sv
// Combinational 5-bit substitution shared by the round datapath.
module sBoxLayer (
  input  logic [4:0] x,
  output logic [4:0] Sx
);

  always_comb begin
    Sx = 5'd0;
    case (x)
      5'd0:  Sx = 5'd4;
      5'd1:  Sx = 5'd11;
      5'd2:  Sx = 5'd31;
      5'd3:  Sx = 5'd20;
      5'd4:  Sx = 5'd26;
      5'd5:  Sx = 5'd21;
      5'd6:  Sx = 5'd9;
      5'd7:  Sx = 5'd2;
      5'd8:  Sx = 5'd27;
      5'd9:  Sx = 5'd5;
      5'd10: Sx = 5'd8;
      5'd11: Sx = 5'd18;
      5'd12: Sx = 5'd29;
      5'd13: Sx = 5'd3;
      5'd14: Sx = 5'd6;
      5'd15: Sx = 5'd28;
      5'd16: Sx = 5'd30;
      5'd17: Sx = 5'd19;
      5'd18: Sx = 5'd7;
      5'd19: Sx = 5'd14;
      5'd20: Sx = 5'd0;
      5'd21: Sx = 5'd13;
      5'd22: Sx = 5'd17;
      5'd23: Sx = 5'd24;
      5'd24: Sx = 5'd16;
      5'd25: Sx = 5'd12;
      5'd26: Sx = 5'd1;
      5'd27: Sx = 5'd25;
      5'd28: Sx = 5'd22;
      5'd29: Sx = 5'd10;
      5'd30: Sx = 5'd15;
      5'd31: Sx = 5'd23;
      default: Sx = 5'd0;
    endcase
  end

endmodule

// File: rtl/sbox_serial_ctrl.sv
// Time-multiplexes one sBoxLayer across all words of a block, one word per
// clock, between an input and an output valid/ready handshake.
module sbox_serial_ctrl #(
  parameter int NUM_WORDS = 8,
  parameter int SBOX_W    = sbox_serial_ctrl_pkg::SBOX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*SBOX_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*SBOX_W-1:0] out_data,
  output logic                        busy
);
  import sbox_serial_ctrl_pkg::*;

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BLK_W = NUM_WORDS * SBOX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [BLK_W-1:0]        buf_reg;
  logic [MAX_BLOCK_W-1:0]  buf_ext;
  logic [SBOX_W-1:0]       sbox_x;
  logic [SBOX_W-1:0]       sbox_y;
  logic                    accept;
  logic                    release_out;
  logic                    running;

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign busy        = (state_reg == RUN);
  assign running     = busy;
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;

  // idx rests at 0 outside RUN, so the S-box sees word 0 there.
  assign buf_ext = MAX_BLOCK_W'(buf_reg);
  assign sbox_x  = word_of(buf_ext, 5'(idx_reg));

  sBoxLayer u_sbox (
    .x  (sbox_x),
    .Sx (sbox_y)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN: begin
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (release_out) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (accept) begin
        buf_reg <= in_data;
      end
    end
  end

  // One result word register per slot, loaded when idx points at it.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [SBOX_W-1:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (running && (idx_reg == IDX_W'(gi))) begin
          word_reg <= sbox_y;
        end
      end

      assign out_data[gi*SBOX_W +: SBOX_W] = word_reg;
    end
  endgenerate

endmodule
